de_pipe_reg: RTL and testbench

DE_PIPE_REG -- requirements
Module: de_pipe_reg

---
 rtl/de_pipe_reg_pkg.sv | 25 ++
 rtl/de_pipe_reg.sv | 105 ++++++++++
 tb/tb_de_pipe_reg.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/de_pipe_reg_pkg.sv
// ============================================================================
// de_pipe_reg_pkg : HILO op codes and D/E pipeline FSM state encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package de_pipe_reg_pkg;

  localparam logic [3:0] HILO_none  = 4'd0;
  localparam logic [3:0] HILO_mult  = 4'd1;
  localparam logic [3:0] HILO_multu = 4'd2;
  localparam logic [3:0] HILO_div   = 4'd3;
  localparam logic [3:0] HILO_divu  = 4'd4;
  localparam logic [3:0] HILO_mfhi  = 4'd5;
  localparam logic [3:0] HILO_mflo  = 4'd6;
  localparam logic [3:0] HILO_mthi  = 4'd7;
  localparam logic [3:0] HILO_mtlo  = 4'd8;

  localparam int         ST_W       = 1;
  localparam logic [ST_W-1:0] ST_RUN     = 1'b0;
  localparam logic [ST_W-1:0] ST_MD_HOLD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/de_pipe_reg.sv
// ============================================================================
// de_pipe_reg : D->E pipeline register with HILO busy stall and bubble insert.
// Optional macro STALL_CNT_EN enables the md-stall cycle counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module de_pipe_reg
  import de_pipe_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_Instr,
  input  logic [31:0] D_RD1,
  input  logic [31:0] D_RD2,
  input  logic [31:0] D_EXT,
  input  logic [3:0]  D_HILOOp,
  input  logic        HILObusy,
  input  logic        hz_stall,
  output logic [31:0] E_PC,
  output logic [31:0] E_Instr,
  output logic [31:0] E_RD1,
  output logic [31:0] E_RD2,
  output logic [31:0] E_EXT,
  output logic [3:0]  E_HILOOp,
  output logic        E_valid,
  output logic        D_stall,
  output logic [31:0] stall_cnt
);

  logic            w_md_stall;
  logic            w_load;
  logic            w_op_issue;
  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_nxt;

  assign w_md_stall = HILObusy && (D_HILOOp != HILO_none);
  assign D_stall    = w_md_stall || hz_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (w_md_stall)  w_state_nxt = ST_MD_HOLD;
      ST_MD_HOLD: if (!w_md_stall) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // While holding, an md op may only issue once the unit has gone idle.
  always_comb begin
    w_load     = !D_stall;
    w_op_issue = w_load;
    if (r_state == ST_MD_HOLD) w_op_issue = w_load && !w_md_stall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      E_PC     <= '0;
      E_Instr  <= '0;
      E_RD1    <= '0;
      E_RD2    <= '0;
      E_EXT    <= '0;
      E_HILOOp <= HILO_none;
      E_valid  <= 1'b0;
    end else if (w_load) begin
      E_PC     <= D_PC;
      E_Instr  <= D_Instr;
      E_RD1    <= D_RD1;
      E_RD2    <= D_RD2;
      E_EXT    <= D_EXT;
      E_HILOOp <= w_op_issue ? D_HILOOp : HILO_none;
      E_valid  <= 1'b1;
    end else begin
      E_PC     <= '0;
      E_Instr  <= '0;
      E_RD1    <= '0;
      E_RD2    <= '0;
      E_EXT    <= '0;
      E_HILOOp <= HILO_none;
      E_valid  <= 1'b0;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_stall_cnt <= '0;
    else if (w_md_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_de_pipe_reg.sv
// ============================================================================
// tb_de_pipe_reg : directed self-checking bench for de_pipe_reg
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_de_pipe_reg;
  import de_pipe_reg_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] D_PC, D_Instr, D_RD1, D_RD2, D_EXT;
  logic [3:0]  D_HILOOp;
  logic        HILObusy, hz_stall;
  logic [31:0] E_PC, E_Instr, E_RD1, E_RD2, E_EXT;
  logic [3:0]  E_HILOOp;
  logic        E_valid, D_stall;
  logic [31:0] stall_cnt;

  int n_tests;
  int n_fail;

`ifdef STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  de_pipe_reg dut (
    .clk(clk), .reset(reset),
    .D_PC(D_PC), .D_Instr(D_Instr), .D_RD1(D_RD1), .D_RD2(D_RD2), .D_EXT(D_EXT),
    .D_HILOOp(D_HILOOp), .HILObusy(HILObusy), .hz_stall(hz_stall),
    .E_PC(E_PC), .E_Instr(E_Instr), .E_RD1(E_RD1), .E_RD2(E_RD2), .E_EXT(E_EXT),
    .E_HILOOp(E_HILOOp), .E_valid(E_valid), .D_stall(D_stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] rd1, input logic [3:0] op,
                       input logic busy, input logic hz);
    D_PC     = pc;
    D_Instr  = instr;
    D_RD1    = rd1;
    D_RD2    = rd1 + 32'd1;
    D_EXT    = pc ^ 32'h0000_FFFF;
    D_HILOOp = op;
    HILObusy = busy;
    hz_stall = hz;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, {31'd0, E_valid}, 32'd0);
    chk({tag, ".op"},    {28'd0, E_HILOOp}, {28'd0, HILO_none});
    chk({tag, ".pc"},    E_PC, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    drive(32'h0000_1234, 32'hDEAD_BEEF, 32'd9, HILO_none, 1'b0, 1'b1);

    // Reset state, and D_stall still combinational during reset
    #2;
    chk("rst.valid", {31'd0, E_valid}, 32'd0);
    chk("rst.pc",    E_PC, 32'd0);
    chk("rst.cnt",   stall_cnt, 32'd0);
    chk("rst.dstall_hz", {31'd0, D_stall}, 32'd1);
    @(negedge clk);
    chk("rst.hold_pc", E_PC, 32'd0);

    // Plain load, one-cycle latency
    reset = 1'b1;
    drive(32'h0000_3000, 32'h0000_0021, 32'd5, HILO_none, 1'b0, 1'b0);
    #1 chk("ld.dstall", {31'd0, D_stall}, 32'd0);
    @(negedge clk);
    chk("ld.pc",    E_PC, 32'h0000_3000);
    chk("ld.rd1",   E_RD1, 32'd5);
    chk("ld.rd2",   E_RD2, 32'd6);
    chk("ld.ext",   E_EXT, 32'h0000_CFFF);
    chk("ld.valid", {31'd0, E_valid}, 32'd1);

    // HILO busy with an md op pending for four cycles
    for (int i = 0; i < 4; i++) begin
      drive(32'h0000_3004, 32'h0085_0018, 32'd7, HILO_mult, 1'b1, 1'b0);
      #1 chk($sformatf("md%0d.dstall", i), {31'd0, D_stall}, 32'd1);
      @(negedge clk);
      chk_bubble($sformatf("md%0d", i));
    end
    chk("md.cnt", stall_cnt, CNT_ON ? 32'd4 : 32'd0);

    // Non-HILO instruction overlaps with the busy unit
    drive(32'h0000_3008, 32'h0085_1021, 32'd11, HILO_none, 1'b1, 1'b0);
    #1 chk("addu.dstall", {31'd0, D_stall}, 32'd0);
    @(negedge clk);
    chk("addu.pc",    E_PC, 32'h0000_3008);
    chk("addu.instr", E_Instr, 32'h0085_1021);
    chk("addu.valid", {31'd0, E_valid}, 32'd1);
    chk("addu.cnt",   stall_cnt, CNT_ON ? 32'd4 : 32'd0);

    // Hazard and md stall together: one bubble, one count
    drive(32'h0000_300C, 32'h0085_001A, 32'd3, HILO_div, 1'b1, 1'b1);
    #1 chk("both.dstall", {31'd0, D_stall}, 32'd1);
    @(negedge clk);
    chk_bubble("both");
    chk("both.cnt", stall_cnt, CNT_ON ? 32'd5 : 32'd0);

    // Hazard stall alone does not count
    drive(32'h0000_3010, 32'h0000_0000, 32'd1, HILO_none, 1'b0, 1'b1);
    @(negedge clk);
    chk_bubble("hz");
    chk("hz.cnt", stall_cnt, CNT_ON ? 32'd5 : 32'd0);

    // Unit idle: md op issues to E
    drive(32'h0000_3014, 32'h0085_0019, 32'd2, HILO_multu, 1'b0, 1'b0);
    @(negedge clk);
    chk("iss.op",    {28'd0, E_HILOOp}, {28'd0, HILO_multu});
    chk("iss.valid", {31'd0, E_valid}, 32'd1);

    // Enter MD_HOLD, then load a real instruction so E_valid = 1
    drive(32'h0000_3018, 32'h0085_001B, 32'd4, HILO_divu, 1'b1, 1'b0);
    @(negedge clk);
    drive(32'h0000_301C, 32'h0000_0025, 32'd8, HILO_none, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre.valid", {31'd0, E_valid}, 32'd1);

    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    chk("arst.valid", {31'd0, E_valid}, 32'd0);
    chk("arst.pc",    E_PC, 32'd0);
    chk("arst.instr", E_Instr, 32'd0);
    chk("arst.cnt",   stall_cnt, 32'd0);
    chk("arst.fsm",   {31'd0, dut.r_state}, {31'd0, ST_RUN});
    drive(32'h0000_3020, 32'h0000_0020, 32'd12, HILO_none, 1'b1, 1'b0);
    #1 chk("arst.dstall", {31'd0, D_stall}, 32'd0);
    @(negedge clk);
    chk("arst.held", {31'd0, E_valid}, 32'd0);

    // First edge after release loads from D
    reset = 1'b1;
    drive(32'h0000_4000, 32'h0000_0024, 32'd13, HILO_mthi, 1'b0, 1'b0);
    @(negedge clk);
    chk("rel.pc",    E_PC, 32'h0000_4000);
    chk("rel.op",    {28'd0, E_HILOOp}, {28'd0, HILO_mthi});
    chk("rel.valid", {31'd0, E_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
